char_convert_seq: RTL and testbench

- Sequential engine behind the MIX CHAR instruction.
- Takes the 30-bit magnitude of rA and produces ten decimal digits, least significant first, one per clock.
- Each cycle it feeds the current value to a combinational divide-by-ten stage (quotient = floor(v/10), remainder = v mod 10) and registers the quotient back as the next value.
- Each digit is converted to a MIX character code and the 60-bit result is returned as new rA and rX contents; the sign is handled by the caller.

---
 rtl/char_convert_seq_if.sv | 12 +
 rtl/char_convert_seq.sv | 91 +++++++++
 tb/tb_char_convert_seq.sv | 130 +++++++++++++
 3 files changed

// File: rtl/char_convert_seq_if.sv
// Handshake and result bus for the CHAR conversion engine.
interface char_convert_seq_if;
    logic        start;
    logic [29:0] in_mag;
    logic        busy;
    logic        done;
    logic [29:0] out_a;
    logic [29:0] out_x;

    modport master (output start, in_mag, input busy, done, out_a, out_x);
    modport slave  (input start, in_mag, output busy, done, out_a, out_x);
endinterface

// File: rtl/char_convert_seq.sv
// MIX CHAR engine: emits ten decimal digits of a 30-bit magnitude, units first,
// one per clock, packing them as character codes into rA/rX images.
module char_convert_div10 (
    input  logic [29:0] value,
    output logic [29:0] quo,
    output logic [3:0]  rem
);
    assign quo = value / 30'd10;
    assign rem = 4'(value - quo * 30'd10);
endmodule

module char_convert_seq #(
    parameter int CHAR_BASE = 30,
    parameter int NDIGITS   = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    char_convert_seq_if.slave   bus
);
    localparam int CW = $clog2(NDIGITS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [29:0]   value;
    logic [CW-1:0] cnt;
    logic [59:0]   shreg;
    logic [29:0]   out_a, out_x;

    logic [29:0]   quo;
    logic [3:0]    rem;
    logic [5:0]    ch;
    logic [59:0]   shreg_nxt;
    logic          last;

    char_convert_div10 u_div (.value(value), .quo(quo), .rem(rem));

    // Newest digit enters at the top; after ten shifts the units digit lands in bits 5:0.
    assign ch        = 6'(CHAR_BASE) + {2'b00, rem};
    assign shreg_nxt = {ch, shreg[59:6]};
    assign last      = (cnt == CW'(NDIGITS - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = bus.start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
            cnt   <= '0;
            shreg <= '0;
            out_a <= '0;
            out_x <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        value <= bus.in_mag;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    value <= quo;
                    shreg <= shreg_nxt;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        out_a <= shreg_nxt[59:30];
                        out_x <= shreg_nxt[29:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy  = (state == RUN);
    assign bus.done  = (state == DONE);
    assign bus.out_a = out_a;
    assign bus.out_x = out_x;
endmodule

// File: tb/tb_char_convert_seq.sv
// Directed plus random checks of the CHAR engine against a decimal reference model.
module tb_char_convert_seq;
    localparam int BASE = 30;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    logic [59:0] held = '0;

    char_convert_seq_if bus ();

    char_convert_seq #(.CHAR_BASE(BASE), .NDIGITS(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [59:0] model(input logic [29:0] v);
        longint unsigned n = v;
        logic [59:0] r = '0;
        for (int i = 0; i < 10; i++) begin
            r[6*i +: 6] = 6'(BASE + int'(n % 10));
            n = n / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues start (from IDLE or the DONE cycle) and follows the conversion to done.
    // poke>0 pulses start with in_mag=5 at that RUN cycle; chain leaves us in DONE.
    task automatic convert(input logic [29:0] v, input logic [59:0] exp,
                           input int poke, input bit chain, input string tag);
        int cyc;
        int busy_cnt;
        bus.start  = 1'b1;
        bus.in_mag = v;
        tick();
        cyc = 1;
        busy_cnt = 0;
        while (!bus.done && cyc < 40) begin
            if (bus.busy) busy_cnt++;
            chk({tag, "_hold"}, {4'h0, bus.out_a, bus.out_x}, {4'h0, held});
            bus.start  = (cyc == poke);
            bus.in_mag = (cyc == poke) ? 30'd5 : 30'($urandom);
            tick();
            cyc++;
        end
        bus.start = 1'b0;
        chk({tag, "_done"}, bus.done, 1'b1);
        chk({tag, "_lat"}, cyc, 11);
        chk({tag, "_busy"}, busy_cnt, 10);
        chk({tag, "_busy_done"}, bus.busy, 1'b0);
        chk({tag, "_res"}, {4'h0, bus.out_a, bus.out_x}, {4'h0, exp});
        held = exp;
        if (!chain) begin
            tick();
            chk({tag, "_pulse"}, {bus.done, bus.busy}, 2'b00);
            chk({tag, "_keep"}, {4'h0, bus.out_a, bus.out_x}, {4'h0, held});
        end
    endtask

    initial begin
        logic [29:0] v;
        int seen;
        bus.start  = 1'b0;
        bus.in_mag = '0;

        repeat (3) tick();
        chk("rst_in", {bus.busy, bus.done, bus.out_a, bus.out_x}, '0);
        rst_n = 1'b1;
        tick();
        chk("rst_out", {bus.busy, bus.done, bus.out_a, bus.out_x}, '0);

        convert(30'd0, {10{6'd30}}, 0, 1'b0, "zero");
        convert(30'd12977699,
                {6'd30, 6'd30, 6'd31, 6'd32, 6'd39, 6'd37, 6'd37, 6'd36, 6'd39, 6'd39},
                0, 1'b0, "typ");
        convert(30'd1073741823,
                {6'd31, 6'd30, 6'd37, 6'd33, 6'd37, 6'd34, 6'd31, 6'd38, 6'd32, 6'd33},
                0, 1'b0, "max");
        convert(30'd12977,
                {6'd30, 6'd30, 6'd30, 6'd30, 6'd30, 6'd31, 6'd32, 6'd39, 6'd37, 6'd37},
                3, 1'b1, "busy_start");
        convert(30'd5, {{9{6'd30}}, 6'd35}, 0, 1'b0, "done_start");

        // Abort in the fourth RUN cycle.
        bus.start  = 1'b1;
        bus.in_mag = 30'd987654321;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("abort_clear", {bus.busy, bus.done, bus.out_a, bus.out_x}, '0);
        held = '0;
        tick();
        rst_n = 1'b1;
        seen = 0;
        repeat (15) begin
            tick();
            if (bus.done || bus.busy) seen++;
        end
        chk("abort_quiet", seen, 0);
        convert(30'd987654321, model(30'd987654321), 0, 1'b0, "post_abort");

        for (int i = 0; i < 16; i++) begin
            v = (i % 4 == 0) ? 30'($urandom_range(0, 999)) : 30'($urandom);
            convert(v, model(v), (i % 3 == 1) ? 5 : 0, (i % 2 == 0), $sformatf("rnd%0d", i));
        end
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
